// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline writeback (A) and buffered
// long-latency results (B) onto the single regfile write port.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   a_valid/a_addr/a_data  pipeline writeback request (cannot stall)
//   a_stall             upstream must hold a_valid low this cycle
//   b_valid/b_ready     long-latency result handshake
//   b_addr/b_data       long-latency result payload
//   q_addr1/2, q_hit1/2 hazard lookup against pending B writes
//   we3/wa3/wd3         registered regfile write port
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_stall,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_hit1,
  output logic        q_hit2,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          we3_q, we3_d;
  logic [4:0]    wa3_q, wa3_d;
  logic [31:0]   wd3_q, wd3_d;
  // Marks the write in flight on we3 as a drained B entry, so its
  // hazard stays visible until the regfile has captured it.
  logic          wb_b_q, wb_b_d;

  logic          nonempty;
  logic          push;
  logic          grant_a;
  logic          grant_b;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic          hit1;
  logic          hit2;
  logic [PW-1:0] off;

  always_comb begin
    nonempty  = (cnt_q != '0);
    b_ready   = !reset && (cnt_q < CW'(DEPTH));
    push      = b_valid && b_ready;
    head_addr = addr_mem[rd_q];
    head_data = data_mem[rd_q];

    // A stall slot belongs to the FIFO head; otherwise A wins.
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (stall_q && nonempty) begin
      grant_b = 1'b1;
    end else if (a_valid) begin
      grant_a = 1'b1;
    end else if (nonempty) begin
      grant_b = 1'b1;
    end

    rd_d = grant_b ? rd_q + PW'(1) : rd_q;
    wr_d = push ? wr_q + PW'(1) : wr_q;

    unique case ({push, grant_b})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    starve_d = '0;
    if (nonempty && !grant_b) begin
      if (starve_q != SW'(STARVE_LIMIT)) begin
        starve_d = starve_q + SW'(1);
      end else begin
        starve_d = starve_q;
      end
    end
    stall_d = (starve_d == SW'(STARVE_LIMIT));

    we3_d  = 1'b0;
    wa3_d  = wa3_q;
    wd3_d  = wd3_q;
    wb_b_d = 1'b0;
    unique case (1'b1)
      grant_a: begin
        we3_d = (a_addr != 5'd0);
        wa3_d = a_addr;
        wd3_d = a_data;
      end
      grant_b: begin
        we3_d  = (head_addr != 5'd0);
        wa3_d  = head_addr;
        wd3_d  = head_data;
        wb_b_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Hazard lookup: occupied slots are those within cnt_q of the head.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_q;
      if ({1'b0, off} < cnt_q) begin
        if (addr_mem[i] == q_addr1) hit1 = 1'b1;
        if (addr_mem[i] == q_addr2) hit2 = 1'b1;
      end
    end
    if (wb_b_q && we3_q && wa3_q == q_addr1) hit1 = 1'b1;
    if (wb_b_q && we3_q && wa3_q == q_addr2) hit2 = 1'b1;
    q_hit1 = hit1 && (q_addr1 != 5'd0);
    q_hit2 = hit2 && (q_addr2 != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_q] <= b_addr;
      data_mem[wr_q] <= b_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      wb_b_q   <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      wb_b_q   <= wb_b_d;
    end
  end

  assign a_stall = stall_q;
  assign we3     = we3_q;
  assign wa3     = wa3_q;
  assign wd3     = wd3_q;

endmodule
